// File: rtl/cpu_mc.sv
// cpu_mc: multicycle CPU for a small MIPS-like subset (FETCH/DECODE/EXEC/MEM/WB), with program-load and debug ports.
// Optional feature: define CPU_MC_JUMP_EN to add the j instruction (opcode 0x02).
module cpu_mc #(
  parameter int DATA_W     = 32,
  parameter int REG_COUNT  = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic [$clog2(REG_COUNT)-1:0]  dbg_reg_addr,
  output logic [DATA_W-1:0]             dbg_reg_data,
  output logic                          busy,
  output logic                          halted,
  output logic                          retire
);
  localparam int IA_W = $clog2(IMEM_DEPTH);
  localparam int RA_W = $clog2(REG_COUNT);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef CPU_MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
`endif
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [IA_W-1:0]   PC_ONE   = {{(IA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_r, state_s;
  logic [IA_W-1:0]   pc_r, npc_s;
  logic [31:0]       ir_r;
  logic [DATA_W-1:0] a_r, b_r, alu_r, mdr_r;
  logic [DATA_W-1:0] alu_s, opb_s, imm_s, wdata_s;
  logic [DATA_W-1:0] regs_r [REG_COUNT];
  logic [31:0]       imem_r [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_r [DMEM_DEPTH];
  logic [5:0]        opcode_s, funct_s;
  logic [RA_W-1:0]   rs_s, rt_s, rd_s, dest_s;
  logic [DA_W-1:0]   daddr_s;
  logic              is_r_s, is_addi_s, is_lw_s, is_sw_s, is_beq_s, is_j_s, legal_s;
  logic              final_entry_s;
  logic              unused_ok;

  assign opcode_s     = ir_r[31:26];
  assign funct_s      = ir_r[5:0];
  assign rs_s         = ir_r[21 +: RA_W];
  assign rt_s         = ir_r[16 +: RA_W];
  assign rd_s         = ir_r[11 +: RA_W];
  assign imm_s        = DATA_W'($signed(ir_r[15:0]));
  assign dest_s       = is_r_s ? rd_s : rt_s;
  assign wdata_s      = is_lw_s ? mdr_r : alu_r;
  assign daddr_s      = alu_r[DA_W-1:0];
  assign dbg_reg_data = regs_r[dbg_reg_addr];
  assign unused_ok    = ^{ir_r[25:21], ir_r[20:16], ir_r[15:11], ir_r[10:6]};

  // Instruction classification; anything not recognised here halts the machine in DECODE.
  always_comb begin
    is_r_s    = 1'b0;
    is_addi_s = 1'b0;
    is_lw_s   = 1'b0;
    is_sw_s   = 1'b0;
    is_beq_s  = 1'b0;
    is_j_s    = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_r_s = 1'b1;
          default:                               is_r_s = 1'b0;
        endcase
      end
      OP_ADDI: is_addi_s = 1'b1;
      OP_LW:   is_lw_s   = 1'b1;
      OP_SW:   is_sw_s   = 1'b1;
      OP_BEQ:  is_beq_s  = 1'b1;
`ifdef CPU_MC_JUMP_EN
      OP_J:    is_j_s    = 1'b1;
`endif
      default: is_r_s    = 1'b0;
    endcase
    legal_s = is_r_s | is_addi_s | is_lw_s | is_sw_s | is_beq_s | is_j_s;
  end

  // ALU: R-type uses rt, everything else adds the sign-extended immediate (addi, address calc).
  always_comb begin
    opb_s = is_r_s ? b_r : imm_s;
    if (is_r_s) begin
      case (funct_s)
        FN_SUB:  alu_s = a_r - opb_s;
        FN_AND:  alu_s = a_r & opb_s;
        FN_OR:   alu_s = a_r | opb_s;
        FN_SLT:  alu_s = ($signed(a_r) < $signed(opb_s)) ? DATA_ONE : {DATA_W{1'b0}};
        default: alu_s = a_r + opb_s;
      endcase
    end else begin
      alu_s = a_r + opb_s;
    end
  end

  // Next PC; operands and IR are stable from DECODE onward so this is valid at commit time.
  always_comb begin
    if (is_beq_s && (a_r == b_r)) begin
      npc_s = pc_r + PC_ONE + ir_r[IA_W-1:0];
    end else if (is_j_s) begin
      npc_s = ir_r[IA_W-1:0];
    end else begin
      npc_s = pc_r + PC_ONE;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_HALT: state_s = start ? S_FETCH : state_r;
      S_FETCH:        state_s = S_DECODE;
      S_DECODE:       state_s = legal_s ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_lw_s || is_sw_s) begin
          state_s = S_MEM;
        end else if (is_beq_s || is_j_s) begin
          state_s = S_FETCH;
        end else begin
          state_s = S_WB;
        end
      end
      S_MEM:   state_s = is_lw_s ? S_WB : S_FETCH;
      S_WB:    state_s = S_FETCH;
      default: state_s = S_IDLE;
    endcase
  end

  // retire is registered on entry to an instruction's last state so it is high throughout that state.
  assign final_entry_s = (state_s == S_WB) ||
                         ((state_s == S_MEM) && is_sw_s) ||
                         ((state_r == S_DECODE) && (state_s == S_EXEC) && (is_beq_s || is_j_s));

  // Control state, PC, IR, operand latches and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      pc_r    <= {IA_W{1'b0}};
      ir_r    <= 32'h0000_0000;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      alu_r   <= {DATA_W{1'b0}};
      busy    <= 1'b0;
      halted  <= 1'b0;
      retire  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != S_IDLE) && (state_s != S_HALT);
      halted  <= (state_s == S_HALT);
      retire  <= final_entry_s;
      if (state_s == S_FETCH) begin
        pc_r <= ((state_r == S_IDLE) || (state_r == S_HALT)) ? {IA_W{1'b0}} : npc_s;
      end
      if (state_r == S_FETCH) begin
        ir_r <= imem_r[pc_r];
      end
      if (state_r == S_DECODE) begin
        a_r <= regs_r[rs_s];
        b_r <= regs_r[rt_s];
      end
      if (state_r == S_EXEC) begin
        alu_r <= alu_s;
      end
    end
  end

  // Register file; register 0 is never written so it always reads zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((state_r == S_WB) && (dest_s != {RA_W{1'b0}})) begin
      regs_r[dest_s] <= wdata_s;
    end
  end

  // Instruction memory: loadable only while stopped, never cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset && prog_we && ((state_r == S_IDLE) || (state_r == S_HALT))) begin
      imem_r[prog_addr] <= prog_data;
    end
  end

  // Data memory with registered read into MDR; a reset in MEM suppresses the store.
  always_ff @(posedge clock) begin
    if (!reset && (state_r == S_MEM) && is_sw_s) begin
      dmem_r[daddr_s] <= b_r;
    end
    mdr_r <= dmem_r[daddr_s];
  end
endmodule

// File: tb/tb_cpu_mc.sv
// Self-checking bench for cpu_mc: directed scenarios plus random programs against an instruction-level model.
module tb_cpu_mc;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = 6'd0;
  logic [31:0] prog_data = 32'd0;
  logic [4:0]  dbg_reg_addr = 5'd0;
  logic [31:0] dbg_reg_data;
  logic        busy, halted, retire;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_imem [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] pq [$];

  cpu_mc dut (
    .clock(clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_reg_addr(dbg_reg_addr),
    .dbg_reg_data(dbg_reg_data), .busy(busy), .halted(halted), .retire(retire)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Instruction-level reference: executes the loaded program, returning cycle and retire counts.
  function automatic void model_run(output int cyc, output int ret);
    int pc, rs, rt, rd, simm;
    logic [31:0] ins, a, b, imm, res;
    logic [5:0] op, fn;
    pc = 0; cyc = 0; ret = 0;
    for (int step = 0; step < 500; step++) begin
      ins = m_imem[pc];
      op = ins[31:26]; fn = ins[5:0];
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      simm = int'($signed(ins[15:0]));
      imm = 32'(simm);
      a = m_regs[rs]; b = m_regs[rt];
      if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
        case (fn)
          6'h20:   res = a + b;
          6'h22:   res = a - b;
          6'h24:   res = a & b;
          6'h25:   res = a | b;
          default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        if (rd != 0) m_regs[rd] = res;
        cyc += 4; pc = (pc + 1) % 64;
      end else if (op == 6'h08) begin
        if (rt != 0) m_regs[rt] = a + imm;
        cyc += 4; pc = (pc + 1) % 64;
      end else if (op == 6'h23) begin
        if (rt != 0) m_regs[rt] = m_dmem[(a + imm) & 32'd63];
        cyc += 5; pc = (pc + 1) % 64;
      end else if (op == 6'h2B) begin
        m_dmem[(a + imm) & 32'd63] = b;
        cyc += 4; pc = (pc + 1) % 64;
      end else if (op == 6'h04) begin
        cyc += 3;
        pc = (a == b) ? ((pc + 1 + simm) & 63) : ((pc + 1) % 64);
`ifdef CPU_MC_JUMP_EN
      end else if (op == 6'h02) begin
        cyc += 3; pc = int'(ins[5:0]);
`endif
      end else begin
        cyc += 2;
        return;
      end
      ret++;
    end
  endfunction

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
  endtask

  // Loads pq at address 0 upward, filling the rest of instruction memory with an illegal word.
  task automatic load_prog();
    for (int a = 0; a < 64; a++) begin
      m_imem[a] = (a < pq.size()) ? pq[a] : ILL;
      @(negedge clock);
      prog_we = 1'b1; prog_addr = 6'(a); prog_data = m_imem[a];
    end
    @(negedge clock); prog_we = 1'b0;
  endtask

  task automatic run_dut(output int cyc, output int ret, output bit to);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    cyc = 0; ret = 0; to = 1'b0;
    while (!halted) begin
      if (cyc >= 2000) begin to = 1'b1; break; end
      @(posedge clock); #1;
      cyc++;
      if (retire) ret++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock); reset = 1'b1; start = 1'b1; prog_we = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0)   begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_checks++; if (retire !== 1'b0) begin n_fails++; $display("FAIL reset_retire: got %b expected 0", retire); end
    dbg_reg_addr = 5'd1; #1;
    n_checks++; if (dbg_reg_data !== 32'd0) begin n_fails++; $display("FAIL reset_reg1: got %h expected 0", dbg_reg_data); end
    @(negedge clock); reset = 1'b0; start = 1'b0; prog_we = 1'b0;
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
  endtask

  task automatic test_basic();
    int mc, mr, c, r; bit to;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 1, 9));
    pq.push_back(enc_i(6'h08, 0, 2, 15));
    pq.push_back(enc_r(5, 1, 2, 6'h20));
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to) begin n_fails++; $display("FAIL basic_timeout: halted never rose"); end
    n_checks++; if (c != mc) begin n_fails++; $display("FAIL basic_cycles: got %0d expected %0d", c, mc); end
    n_checks++; if (r != 3) begin n_fails++; $display("FAIL basic_retires: got %0d expected 3", r); end
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL basic_busy: got %b expected 0", busy); end
    dbg_reg_addr = 5'd5; #1;
    n_checks++; if (dbg_reg_data !== 32'd24) begin n_fails++; $display("FAIL basic_r5: got %0d expected 24", dbg_reg_data); end
  endtask

  task automatic test_mem();
    int mc, mr, c, r; bit to;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 3, 25));
    pq.push_back(enc_i(6'h08, 0, 4, 29));
    pq.push_back(enc_i(6'h2B, 4, 3, 9));
    pq.push_back(enc_i(6'h23, 3, 9, 13));
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != mc || r != mr) begin n_fails++; $display("FAIL mem_cycles: got %0d/%0d expected %0d/%0d", c, r, mc, mr); end
    dbg_reg_addr = 5'd9; #1;
    n_checks++; if (dbg_reg_data !== 32'd25) begin n_fails++; $display("FAIL mem_r9: got %0d expected 25", dbg_reg_data); end
    // A lone lw isolates its 5-cycle latency and rereads dmem[38].
    pq.delete();
    pq.push_back(enc_i(6'h23, 0, 10, 38));
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != 7) begin n_fails++; $display("FAIL lw_cycles: got %0d expected 7", c); end
    dbg_reg_addr = 5'd10; #1;
    n_checks++; if (dbg_reg_data !== 32'd25) begin n_fails++; $display("FAIL lw_dmem38: got %0d expected 25", dbg_reg_data); end
  endtask

  task automatic test_branch();
    int mc, mr, c, r; bit to;
    for (int taken = 1; taken >= 0; taken--) begin
      do_reset();
      pq.delete();
      pq.push_back(enc_i(6'h08, 0, 3, 7));
      pq.push_back(enc_i(6'h08, 0, 9, (taken != 0) ? 7 : 8));
      for (int k = 2; k <= 10; k++) pq.push_back(enc_i(6'h08, 0, 0, 0));
      pq.push_back(enc_i(6'h04, 3, 9, 10));
      pq.push_back(enc_i(6'h08, 0, 10, 1));
      for (int k = 13; k <= 21; k++) pq.push_back(ILL);
      pq.push_back(enc_i(6'h08, 0, 11, 2));
      load_prog();
      model_run(mc, mr);
      run_dut(c, r, to);
      n_checks++; if (to || c != mc || r != mr) begin n_fails++; $display("FAIL beq_cycles t=%0d: got %0d/%0d expected %0d/%0d", taken, c, r, mc, mr); end
      dbg_reg_addr = 5'd10; #1;
      n_checks++; if (dbg_reg_data !== ((taken != 0) ? 32'd0 : 32'd1)) begin n_fails++; $display("FAIL beq_r10 t=%0d: got %0d", taken, dbg_reg_data); end
      dbg_reg_addr = 5'd11; #1;
      n_checks++; if (dbg_reg_data !== ((taken != 0) ? 32'd2 : 32'd0)) begin n_fails++; $display("FAIL beq_r11 t=%0d: got %0d", taken, dbg_reg_data); end
    end
  endtask

  task automatic test_slt_r0();
    int mc, mr, c, r; bit to;
    logic [31:0] exp_v [5];
    int idx [5];
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 3, -1));
    pq.push_back(enc_i(6'h08, 0, 4, 1));
    pq.push_back(enc_i(6'h08, 0, 0, 5));
    pq.push_back(enc_r(8, 3, 4, 6'h2A));
    pq.push_back(enc_r(12, 4, 3, 6'h22));
    pq.push_back(enc_r(13, 3, 4, 6'h24));
    pq.push_back(enc_r(14, 3, 4, 6'h25));
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != mc) begin n_fails++; $display("FAIL alu_cycles: got %0d expected %0d", c, mc); end
    idx = '{0, 8, 12, 13, 14};
    exp_v = '{32'd0, 32'd1, 32'd2, 32'd1, 32'hFFFF_FFFF};
    for (int k = 0; k < 5; k++) begin
      dbg_reg_addr = 5'(idx[k]); #1;
      n_checks++; if (dbg_reg_data !== exp_v[k]) begin n_fails++; $display("FAIL alu_r%0d: got %h expected %h", idx[k], dbg_reg_data, exp_v[k]); end
    end
  endtask

  task automatic test_dbg_old();
    bit got;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 1, 9));
    pq.push_back(ILL);
    load_prog();
    dbg_reg_addr = 5'd1;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clock); #1;
      if (retire) got = 1'b1;
    end
    n_checks++; if (!got) begin n_fails++; $display("FAIL dbg_retire_timeout: no retire seen"); end
    n_checks++; if (dbg_reg_data !== 32'd0) begin n_fails++; $display("FAIL dbg_old: got %0d expected 0", dbg_reg_data); end
    @(posedge clock); #1;
    n_checks++; if (dbg_reg_data !== 32'd9) begin n_fails++; $display("FAIL dbg_new: got %0d expected 9", dbg_reg_data); end
    for (int k = 0; k < 20 && !halted; k++) @(posedge clock);
  endtask

  task automatic test_prog_busy();
    int mc, mr, c, r; bit to;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 1, 3));
    pq.push_back(enc_i(6'h08, 0, 2, 4));
    pq.push_back(ILL);
    load_prog();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    prog_we = 1'b1; prog_addr = 6'd2; prog_data = enc_i(6'h08, 0, 3, 5);
    @(negedge clock); prog_we = 1'b0;
    for (int k = 0; k < 50 && !halted; k++) @(posedge clock);
    #1;
    n_checks++; if (halted !== 1'b1) begin n_fails++; $display("FAIL busy_we_halt: got %b expected 1", halted); end
    dbg_reg_addr = 5'd3; #1;
    n_checks++; if (dbg_reg_data !== 32'd0) begin n_fails++; $display("FAIL busy_we_r3: got %0d expected 0", dbg_reg_data); end
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != mc || r != mr) begin n_fails++; $display("FAIL restart_halt: got %0d/%0d expected %0d/%0d", c, r, mc, mr); end
  endtask

  task automatic test_reset_mid();
    int mc, mr, c, r; bit to;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 1, 9));
    pq.push_back(enc_i(6'h08, 0, 2, 15));
    pq.push_back(enc_r(5, 1, 2, 6'h20));
    pq.push_back(ILL);
    load_prog();
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    n_checks++; if (busy !== 1'b1 || retire !== 1'b0) begin n_fails++; $display("FAIL mid_exec: busy=%b retire=%b expected 1/0", busy, retire); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fails++; $display("FAIL mid_idle: busy=%b halted=%b expected 0/0", busy, halted); end
    dbg_reg_addr = 5'd5; #1;
    n_checks++; if (dbg_reg_data !== 32'd0) begin n_fails++; $display("FAIL mid_r5: got %0d expected 0", dbg_reg_data); end
    @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != mc || r != mr) begin n_fails++; $display("FAIL mid_rerun: got %0d/%0d expected %0d/%0d", c, r, mc, mr); end
    dbg_reg_addr = 5'd5; #1;
    n_checks++; if (dbg_reg_data !== 32'd24) begin n_fails++; $display("FAIL mid_rerun_r5: got %0d expected 24", dbg_reg_data); end
  endtask

  task automatic test_jump();
    int mc, mr, c, r; bit to;
    do_reset();
    pq.delete();
    pq.push_back(enc_i(6'h08, 0, 2, 2));
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    pq.delete();
    pq.push_back(enc_i(6'h08, 1, 1, 1));
    pq.push_back(enc_i(6'h04, 1, 2, 2));
    pq.push_back(enc_i(6'h08, 0, 0, 0));
    pq.push_back({6'h02, 26'd0});
    pq.push_back(ILL);
    load_prog();
    model_run(mc, mr);
    run_dut(c, r, to);
    n_checks++; if (to || c != mc || r != mr) begin n_fails++; $display("FAIL jump_cycles: got %0d/%0d expected %0d/%0d", c, r, mc, mr); end
    dbg_reg_addr = 5'd1; #1;
`ifdef CPU_MC_JUMP_EN
    n_checks++; if (dbg_reg_data !== 32'd2) begin n_fails++; $display("FAIL jump_r1: got %0d expected 2", dbg_reg_data); end
`else
    n_checks++; if (dbg_reg_data !== 32'd1) begin n_fails++; $display("FAIL jump_r1: got %0d expected 1", dbg_reg_data); end
    pq.delete();
    pq.push_back({6'h02, 26'd0});
    load_prog();
    run_dut(c, r, to);
    n_checks++; if (to || r != 0 || halted !== 1'b1) begin n_fails++; $display("FAIL jump_disabled: retires=%0d halted=%b expected 0/1", r, halted); end
`endif
  endtask

  task automatic test_random();
    int mc, mr, c, r, kind; bit to;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int p = 0; p < 8; p++) begin
      do_reset();
      pq.delete();
      for (int a = 0; a < 8; a++) pq.push_back(enc_i(6'h2B, 0, 0, a));
      for (int k = 0; k < 14; k++) begin
        kind = int'($urandom_range(0, 12));
        if (kind <= 3)       pq.push_back(enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 65535))));
        else if (kind <= 7)  pq.push_back(enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]));
        else if (kind == 8)  pq.push_back(enc_i(6'h23, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        else if (kind == 9)  pq.push_back(enc_i(6'h2B, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        else if (kind <= 11) pq.push_back(enc_i(6'h04, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3))));
        else                 pq.push_back(enc_r(1, 1, 1, 6'h21));
      end
      load_prog();
      model_run(mc, mr);
      run_dut(c, r, to);
      n_checks++; if (to || c != mc) begin n_fails++; $display("FAIL rnd%0d_cycles: got %0d expected %0d", p, c, mc); end
      n_checks++; if (r != mr) begin n_fails++; $display("FAIL rnd%0d_retires: got %0d expected %0d", p, r, mr); end
      for (int k = 0; k < 8; k++) begin
        dbg_reg_addr = 5'(k); #1;
        n_checks++; if (dbg_reg_data !== m_regs[k]) begin n_fails++; $display("FAIL rnd%0d_r%0d: got %h expected %h", p, k, dbg_reg_data, m_regs[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mem();
    test_branch();
    test_slt_r0();
    test_dbg_old();
    test_prog_busy();
    test_reset_mid();
    test_jump();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
